// File: rtl/maxpool_2x2_s2_ctrl.sv
// Stride-2 2x2 max-pool controller: tracks pixel position behind the line buffer,
// keeps windows whose bottom-right pixel sits at odd row/odd column, and emits their signed max.
module maxpool_2x2_s2_ctrl #(
  parameter int ROW_W1 = 16,
  parameter int ROW_W2 = 30,
  parameter int ROW_W3 = 58,
  parameter int ROW_W4 = 114,
  parameter int ROW_W5 = 226,
  parameter int ROW_W6 = 450,
  parameter int CNT_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  sel,
  input  logic        pix_valid,
  input  logic [31:0] ifm_win2x2_batch,
  output logic [7:0]  pool_out,
  output logic        pool_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   w_q, r_q, c_q;
  logic [1:0]         dcnt_q;
  logic               busy_q, frame_err_q;

  logic               v0_q, l0_q, v1_q, l1_q;
  logic [7:0]         m0_q, m1_q;
  logic [7:0]         pool_out_q;
  logic               pool_valid_q, frame_done_q;

  logic               last_pix_d, keep_d;
  logic [CNT_W-1:0]   w_sel_d;

  function automatic logic [CNT_W-1:0] sel_width(input logic [2:0] s);
    case (s)
      3'd0:    return CNT_W'(ROW_W1);
      3'd1:    return CNT_W'(ROW_W2);
      3'd2:    return CNT_W'(ROW_W3);
      3'd3:    return CNT_W'(ROW_W4);
      3'd4:    return CNT_W'(ROW_W5);
      default: return CNT_W'(ROW_W6);
    endcase
  endfunction

  function automatic logic [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_sel_d    = sel_width(sel);
  assign last_pix_d = (state_q == RUN) && pix_valid &&
                      (r_q == w_q - 1'b1) && (c_q == w_q - 1'b1);
  // Counters sit at 0 outside RUN, so the first pixel of a frame is never kept.
  assign keep_d     = pix_valid && r_q[0] && c_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pix_valid) begin
            state_q <= RUN;
            w_q     <= w_sel_d;
            r_q     <= '0;
            c_q     <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!pix_valid) begin
            // Line buffer keeps shifting, so data is already corrupt; just flag it.
            frame_err_q <= 1'b1;
          end else if (last_pix_d) begin
            state_q <= DRAIN;
            r_q     <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
          end else if (c_q == w_q - 1'b1) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pix_valid) begin
            state_q <= RUN;
            w_q     <= w_sel_d;
            r_q     <= '0;
            c_q     <= CNT_W'(1);
          end else if (dcnt_q == 2'd2) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // End-of-frame marker rides the valid pipeline so overlapping frames stay ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q         <= 1'b0;
      l0_q         <= 1'b0;
      v1_q         <= 1'b0;
      l1_q         <= 1'b0;
      m0_q         <= '0;
      m1_q         <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      v0_q         <= keep_d;
      l0_q         <= last_pix_d;
      v1_q         <= v0_q;
      l1_q         <= l0_q;
      pool_valid_q <= v1_q;
      frame_done_q <= v1_q && l1_q;
      if (v0_q) begin
        m0_q <= smax(ifm_win2x2_batch[7:0],   ifm_win2x2_batch[15:8]);
        m1_q <= smax(ifm_win2x2_batch[23:16], ifm_win2x2_batch[31:24]);
      end
      if (v1_q) begin
        pool_out_q <= smax(m0_q, m1_q);
      end
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_maxpool_2x2_s2_ctrl.sv
// Bench for maxpool_2x2_s2_ctrl: an ideal line buffer feeds windows, and a frame-level
// model (block maxima of the image) predicts every pooled output and frame end.
module tb_maxpool_2x2_s2_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        pix_valid = 1'b0;
  logic [31:0] ifm_win2x2_batch = 32'd0;
  logic [7:0]  pool_out;
  logic        pool_valid, frame_done, frame_err, busy;

  always #5 clk = ~clk;

  maxpool_2x2_s2_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sel              (sel),
    .pix_valid        (pix_valid),
    .ifm_win2x2_batch (ifm_win2x2_batch),
    .pool_out         (pool_out),
    .pool_valid       (pool_valid),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  typedef struct {
    logic [7:0] val;
    bit         last;
  } exp_t;

  typedef struct {
    logic [31:0] win;
    logic [7:0]  exp;
  } vec_t;

  int          checks_total = 0;
  int          checks_passed = 0;
  exp_t        exp_q[$];
  logic [7:0]  got_q[$];
  exp_t        e;
  int          fd_count = 0;
  int          cyc = 0;
  int          first_pv_cyc = -1;
  int          pix11_cyc = 0;
  byte         img [450][450];
  logic [31:0] pending_win = 32'd0;
  vec_t        vec [8];

  task automatic check(input string name, input longint act, input longint req);
    checks_total++;
    if (act == req) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pool_valid) begin
        got_q.push_back(pool_out);
        if (first_pv_cyc < 0) first_pv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pool_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pool_out", pool_out, e.val);
          check("frame_done_align", frame_done, e.last);
        end
      end else if (frame_done) begin
        check("frame_done_without_valid", 1, 0);
      end
      if (frame_done) fd_count++;
    end
  end

  function automatic logic [7:0] max4(input byte a, input byte b, input byte c, input byte d);
    byte m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [31:0] win_of(input int r, input int c);
    logic [7:0] tl = 8'd0, tr = 8'd0, bl = 8'd0, br;
    br = img[r][c];
    if (r > 0) tr = img[r-1][c];
    if (c > 0) bl = img[r][c-1];
    if (r > 0 && c > 0) tl = img[r-1][c-1];
    return {br, bl, tr, tl};
  endfunction

  // Window of the pixel sent in the previous cycle appears now, as a real line buffer would.
  task automatic step(input bit v, input int r, input int c);
    ifm_win2x2_batch = pending_win;
    pix_valid = v;
    if (v) pending_win = win_of(r, c);
    @(posedge clk);
    #1;
  endtask

  // mode 0: (r*w+c) mod 128, 1: random, 2: random with vec[] in the first row pair
  task automatic send_frame(input int s, input int w, input int mode,
                            input int gap_r, input int gap_c, input int gap_len,
                            input int npix);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = (mode == 0) ? byte'((r * w + c) % 128) : byte'($urandom);
    if (mode == 2) begin
      for (int k = 0; k < 8; k++) begin
        img[0][2*k]   = vec[k].win[7:0];
        img[0][2*k+1] = vec[k].win[15:8];
        img[1][2*k]   = vec[k].win[23:16];
        img[1][2*k+1] = vec[k].win[31:24];
      end
    end
    for (int i = 0; i < w / 2; i++)
      for (int j = 0; j < w / 2; j++) begin
        exp_t x;
        x.val  = max4(img[2*i][2*j], img[2*i][2*j+1], img[2*i+1][2*j], img[2*i+1][2*j+1]);
        x.last = (i == w / 2 - 1) && (j == w / 2 - 1);
        exp_q.push_back(x);
      end
    sel = 3'(s);
    for (int idx = 0; idx < npix; idx++) begin
      int r = idx / w;
      int c = idx % w;
      if (r == gap_r && c == gap_c)
        for (int g = 0; g < gap_len; g++) step(1'b0, 0, 0);
      if (r == 1 && c == 1) pix11_cyc = cyc;
      step(1'b1, r, c);
      if (idx == 0) sel = 3'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      step(1'b0, 0, 0);
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    repeat (2) step(1'b0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    vec[0] = '{32'h007FFF80, 8'h7F};
    vec[1] = '{32'h80808080, 8'h80};
    vec[2] = '{32'h04030201, 8'h04};
    vec[3] = '{32'h8180FEFF, 8'hFF};
    vec[4] = '{32'h80807F7F, 8'h7F};
    vec[5] = '{32'hB0A09000, 8'h00};
    vec[6] = '{32'h82838485, 8'h85};
    vec[7] = '{32'hFBFCFDFE, 8'hFE};

    repeat (3) @(posedge clk);
    #1;
    check("reset_pool_out", pool_out, 0);
    check("reset_pool_valid", pool_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 0, 0);

    // W=16 ramp frame
    got_q.delete(); first_pv_cyc = -1; fd0 = fd_count;
    send_frame(0, 16, 0, -1, -1, 0, 256);
    wait_drain("ramp");
    check("ramp_count", got_q.size(), 64);
    check("ramp_latency", first_pv_cyc - pix11_cyc, 3);
    check("ramp_first", got_q[0], 17);
    check("ramp_last", got_q[63], 127);
    check("ramp_frame_done", fd_count - fd0, 1);
    check("ramp_busy_after", busy, 0);
    check("ramp_frame_err", frame_err, 0);

    // Signed-compare vector table on kept positions
    got_q.delete();
    send_frame(0, 16, 2, -1, -1, 0, 256);
    wait_drain("signed");
    for (int k = 0; k < 8; k++)
      check($sformatf("signed_vec%0d", k), got_q[k], vec[k].exp);

    // Back-to-back: second frame starts in the first DRAIN cycle with sel=1
    got_q.delete(); fd0 = fd_count;
    send_frame(0, 16, 1, -1, -1, 0, 256);
    send_frame(1, 30, 1, -1, -1, 0, 900);
    wait_drain("b2b");
    check("b2b_count", got_q.size(), 64 + 225);
    check("b2b_frame_done", fd_count - fd0, 2);
    check("b2b_frame_err", frame_err, 0);

    // Gap of 2 cycles at pixel (3,5)
    got_q.delete(); fd0 = fd_count;
    send_frame(0, 16, 1, 3, 5, 2, 256);
    wait_drain("gap");
    check("gap_frame_err", frame_err, 1);
    check("gap_frame_done", fd_count - fd0, 1);
    got_q.delete();
    send_frame(0, 16, 1, -1, -1, 0, 256);
    wait_drain("post_gap");
    check("post_gap_count", got_q.size(), 64);
    check("post_gap_err_sticky", frame_err, 1);

    // Reset one cycle before the pixel (1,1) result would appear
    got_q.delete();
    send_frame(0, 16, 0, -1, -1, 0, 18);
    step(1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_pool_out", pool_out, 0);
    check("midrst_pool_valid", pool_valid, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    repeat (2) step(1'b0, 0, 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (6) step(1'b0, 0, 0);
    check("midrst_no_pool_valid", got_q.size(), 0);
    check("midrst_idle_busy", busy, 0);

    // sel=7 selects W=450: first kept pixel is (1,1), index 451
    got_q.delete(); first_pv_cyc = -1;
    send_frame(7, 450, 1, -1, -1, 0, 452);
    repeat (4) step(1'b0, 0, 0);
    check("sel7_count", got_q.size(), 1);
    check("sel7_latency", first_pv_cyc - pix11_cyc, 3);
    check("sel7_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) step(1'b0, 0, 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) step(1'b0, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
